// File: rtl/fifo_mem_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_mem_ctrl
// Single-clock controller for a single-port FIFO storage array. It holds the
// write/read pointers and the occupancy, and puts at most one producer or
// consumer access on the shared memory port per cycle. Requests are
// round-robin arbitrated when both can proceed. After reset or flush the
// whole array is written with zeros (INIT, DEPTH cycles) before traffic is
// accepted.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of contents, re-runs INIT
//   wr_req/wr_data      producer request and data, held until wr_ack
//   wr_ack              write granted this cycle
//   rd_req              consumer request, held until rd_ack
//   rd_ack              read granted this cycle
//   rd_valid/rd_data    read data, one cycle after rd_ack
//   full/empty/count    occupancy status (count is 0..DEPTH)
//   busy                high while the array is being initialised
//   mem_*               storage array port (one pointer, w/r enables)
// ---------------------------------------------------------------------------
module fifo_mem_ctrl #(
   parameter int DW = 33,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_req,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic          rd_req,
   output logic          rd_ack,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          busy,
   output logic [AW-1:0] mem_pntr,
   output logic          mem_w_e,
   output logic          mem_r_e,
   output logic [DW-1:0] mem_w_data,
   input  logic [DW-1:0] mem_r_data
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_RUN}          state_t;
   typedef enum logic {GRANT_READ, GRANT_WRITE}  grant_t;

   state_t        state_q, state_d;
   grant_t        last_grant_q, last_grant_d;
   logic [AW-1:0] init_cnt_q, init_cnt_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rd_valid_q, rd_valid_d;
   logic          wr_ok, rd_ok;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign busy     = (state_q == ST_INIT);
   assign rd_valid = rd_valid_q;
   // The array registers its output, so the word for a read granted last
   // cycle is on mem_r_data exactly while rd_valid is high.
   assign rd_data  = mem_r_data;

   assign wr_ok = wr_req & ~full;
   assign rd_ok = rd_req & ~empty;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves one unassigned, which would infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      init_cnt_d   = init_cnt_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      count_d      = count_q;
      wr_ack       = 1'b0;
      rd_ack       = 1'b0;
      mem_w_e      = 1'b0;
      mem_r_e      = 1'b0;
      mem_pntr     = rptr_q;
      mem_w_data   = '0;

      case (state_q)
         ST_INIT: begin
            mem_w_e    = 1'b1;
            mem_pntr   = init_cnt_q;
            init_cnt_d = init_cnt_q + AW'(1);
            if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!flush) begin
               // On contention the side that did not win last time goes.
               if (wr_ok && (!rd_ok || last_grant_q == GRANT_READ)) begin
                  wr_ack       = 1'b1;
                  mem_w_e      = 1'b1;
                  mem_pntr     = wptr_q;
                  mem_w_data   = wr_data;
                  wptr_d       = wptr_q + AW'(1);
                  count_d      = count_q + (AW+1)'(1);
                  last_grant_d = GRANT_WRITE;
               end else if (rd_ok) begin
                  rd_ack       = 1'b1;
                  mem_r_e      = 1'b1;
                  mem_pntr     = rptr_q;
                  rptr_d       = rptr_q + AW'(1);
                  count_d      = count_q - (AW+1)'(1);
                  last_grant_d = GRANT_READ;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase

      if (flush) begin
         state_d      = ST_INIT;
         init_cnt_d   = '0;
         wptr_d       = '0;
         rptr_d       = '0;
         count_d      = '0;
         last_grant_d = GRANT_READ;
      end

      rd_valid_d = rd_ack;
   end

   // NOTE: the storage array itself is not reset; INIT clears it through the
   // normal write port, so only this small control state needs a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         last_grant_q <= GRANT_READ;
         init_cnt_q   <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         init_cnt_q   <= init_cnt_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_mem_ctrl
// Self-checking bench for fifo_mem_ctrl. A queue-based FIFO model predicts
// grants, occupancy, memory-port activity and read data every cycle; a
// behavioural storage array answers the controller's memory port.
// ---------------------------------------------------------------------------
module tb_fifo_mem_ctrl;

   localparam int DW    = 33;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_req = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_req = 1'b0;
   logic          wr_ack, rd_ack, rd_valid, full, empty, busy;
   logic          mem_w_e, mem_r_e;
   logic [DW-1:0] rd_data, mem_w_data;
   logic [DW-1:0] mem_r_data = '0;
   logic [AW:0]   count;
   logic [AW-1:0] mem_pntr;

   logic [DW-1:0] mem [DEPTH];

   fifo_mem_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .full(full), .empty(empty), .count(count), .busy(busy),
      .mem_pntr(mem_pntr), .mem_w_e(mem_w_e), .mem_r_e(mem_r_e),
      .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
   );

   always #5 clk = ~clk;

   // Storage array: registered read, data valid the cycle after mem_r_e.
   always @(posedge clk) begin
      if (mem_w_e) mem[mem_pntr] <= mem_w_data;
      if (mem_r_e) mem_r_data <= mem[mem_pntr];
   end

   // ---------------- reference model ----------------
   bit            m_init;
   int            m_idx;
   logic [DW-1:0] m_q[$];
   bit            m_prefer_wr;
   int            m_wr_n, m_rd_n;
   bit            m_pend;
   logic [DW-1:0] m_pend_data;
   bit            g_wr, g_rd;

   int total = 0;
   int bad   = 0;
   bit obs_busy, obs_wr_ack;
   int max_count;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_init      = 1'b1;
      m_idx       = 0;
      m_q.delete();
      m_prefer_wr = 1'b1;
      m_wr_n      = 0;
      m_rd_n      = 0;
      m_pend      = 1'b0;
   endtask

   // One clock: predict and compare at the falling edge, advance the model
   // at the rising edge, then return 1 time unit later for new stimulus.
   task automatic step();
      bit wr_ok, rd_ok;
      int n;
      logic [AW-1:0] exp_pntr;
      @(negedge clk);
      n    = m_q.size();
      g_wr = 1'b0;
      g_rd = 1'b0;
      if (!m_init && !flush) begin
         wr_ok = wr_req && (n < DEPTH);
         rd_ok = rd_req && (n > 0);
         if (wr_ok && rd_ok) begin
            g_wr = m_prefer_wr;
            g_rd = !m_prefer_wr;
         end else begin
            g_wr = wr_ok;
            g_rd = rd_ok;
         end
      end
      if (m_init)    exp_pntr = AW'(m_idx);
      else if (g_wr) exp_pntr = AW'(m_wr_n % DEPTH);
      else           exp_pntr = AW'(m_rd_n % DEPTH);

      obs_busy   = busy;
      obs_wr_ack = wr_ack;
      if (int'(count) > max_count) max_count = int'(count);

      check("busy", busy, m_init);
      check("count", count, n);
      check("full", full, n == DEPTH);
      check("empty", empty, n == 0);
      check("wr_ack", wr_ack, g_wr);
      check("rd_ack", rd_ack, g_rd);
      check("mem_w_e", mem_w_e, m_init || g_wr);
      check("mem_r_e", mem_r_e, g_rd);
      check("mem_pntr", mem_pntr, exp_pntr);
      check("mem_w_data", mem_w_data, g_wr ? wr_data : '0);
      check("rd_valid", rd_valid, m_pend);
      if (m_pend) check("rd_data", rd_data, m_pend_data);

      @(posedge clk);
      if (flush) begin
         model_reset();
      end else if (m_init) begin
         if (m_idx == DEPTH - 1) m_init = 1'b0;
         m_idx++;
         m_pend = 1'b0;
      end else begin
         m_pend = g_rd;
         if (g_wr) begin
            m_q.push_back(wr_data);
            m_wr_n++;
            m_prefer_wr = 1'b0;
         end
         if (g_rd) begin
            m_pend_data = m_q.pop_front();
            m_rd_n++;
            m_prefer_wr = 1'b1;
         end
      end
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      bit acked = 1'b0;
      wr_data = d;
      wr_req  = 1'b1;
      for (int i = 0; i < 100 && !acked; i++) begin
         step();
         acked = g_wr;
      end
      wr_req = 1'b0;
      check("push_ack", acked, 1'b1);
   endtask

   task automatic pop();
      bit acked = 1'b0;
      rd_req = 1'b1;
      for (int i = 0; i < 100 && !acked; i++) begin
         step();
         acked = g_rd;
      end
      rd_req = 1'b0;
      check("pop_ack", acked, 1'b1);
   endtask

   task automatic wait_init(input string tag);
      int busy_cycles = 0;
      for (int i = 0; i < 100 && m_init; i++) begin
         step();
         if (obs_busy) busy_cycles++;
      end
      check(tag, busy_cycles, DEPTH);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #2;
      check("rst_busy", busy, 1'b1);
      check("rst_count", count, 0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_pntr", mem_pntr, 0);
      check("rst_acks", {wr_ack, rd_ack}, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [5:0] pattern;
      model_reset();
      max_count = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Initialisation after reset
      wait_init("init_len");
      step();
      check("post_init_empty", empty, 1'b1);

      // Small in-order transfer
      push(33'h1_0000_0001);
      push(33'h0_DEAD_BEEF);
      push(33'h1_2345_6789);
      repeat (3) pop();
      step();
      check("drained_empty", empty, 1'b1);

      // Fill to full, stall, one read releases the writer
      for (int i = 0; i < DEPTH; i++) push(DW'({$urandom(), $urandom()}));
      check("fill_full", full, 1'b1);
      check("fill_count", count, DEPTH);
      wr_data = 33'h1_5555_AAAA;
      wr_req  = 1'b1;
      repeat (3) begin
         step();
         check("stall_wr_ack", obs_wr_ack, 1'b0);
      end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      step();
      check("unstall_wr_ack", obs_wr_ack, 1'b1);
      wr_req = 1'b0;
      check("refill_count", count, DEPTH);
      repeat (DEPTH) pop();
      step();

      // Round-robin with both sides held at count=4 (last grant was a read)
      repeat (5) push(DW'({$urandom(), $urandom()}));
      pop();
      pattern = '0;
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      wr_data = DW'({$urandom(), $urandom()});
      for (int i = 0; i < 6; i++) begin
         step();
         pattern = {pattern[4:0], obs_wr_ack};
         if (g_wr) wr_data = DW'({$urandom(), $urandom()});
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      check("rr_pattern", pattern, 6'b101010);
      check("rr_count", count, 4);
      repeat (4) pop();
      step();

      // Pointer wrap with alternating write/read
      max_count = 0;
      for (int i = 0; i < 40; i++) begin
         push(DW'({$urandom(), $urandom()}));
         pop();
      end
      step();
      check("pair_max_count", max_count, 1);

      // Flush with data present
      repeat (10) push(DW'({$urandom(), $urandom()}));
      check("preflush_count", count, 10);
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_init("flush_init_len");
      check("flush_count", count, 0);
      check("flush_empty", empty, 1'b1);

      // Reset in the middle of INIT restarts from entry 0
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 100 && m_idx != 12; i++) step();
      reset_pulse();
      wait_init("rst_init_len");

      // Reset while a read result is pending drops rd_valid
      push(DW'({$urandom(), $urandom()}));
      push(DW'({$urandom(), $urandom()}));
      pop();
      check("pre_rst_rd_valid", rd_valid, 1'b1);
      reset_pulse();
      wait_init("rst2_init_len");

      // Randomised traffic with occasional flush
      for (int i = 0; i < 3000; i++) begin
         int wr_pct;
         wr_pct = ((i / 400) % 2 == 1) ? 80 : 30;
         if (!wr_req) begin
            wr_req  = ($urandom_range(0, 99) < wr_pct);
            wr_data = DW'({$urandom(), $urandom()});
         end
         if (!rd_req) rd_req = ($urandom_range(0, 99) < 100 - wr_pct);
         flush = ($urandom_range(0, 399) == 0);
         step();
         if (g_wr) wr_req = 1'b0;
         if (g_rd) rd_req = 1'b0;
      end
      flush  = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
